tick_sched: RTL and testbench
=============================

# tick_sched

Multi-channel periodic tick scheduler: N independent periodic strobes share one W-bit decrement/compare datapath, serviced round-robin one channel per clock. It replaces N separate countdown/strobe instances where strobe rates are low relative to the clock. It sits between the register/config bus, which writes per-channel periods, and the consumers of per-channel tick pulses.

## Interface
Parameters:
- W, 8: period/count width.
- S, 2: channel index width; channel count N = 2**S.
- START, 0: reset value of every period and count register; 0 means disabled.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- sel  in  S  channel addressed by put.
- value  in  W  new period for channel sel.
- put  in  1  write strobe; accepted every cycle, no backpressure.
- act  out  N  one-hot tick pulses, registered.
- cur  out  S  channel serviced in the current cycle (ptr).

## Operation
State:
- ptr[S-1:0]: service pointer.
- period[N] and count[N]: W-bit register arrays.
- act: registered output.

Reset (async):
- ptr = 0; every period and count = START; act = 0.

Every cycle, ptr increments modulo N. Wrap from N-1 to 0 is natural overflow.

Service of channel k = ptr, when not overridden by put to k:
- period[k] == 0: channel disabled; count[k] held; no tick.
- count[k] == 1: tick; count[k] <= period[k].
- count[k] > 1: count[k] <= count[k] - 1.
- count[k] == 0 with period[k] != 0: unreachable; treat as disabled (hold).

Put, when put = 1:
- period[sel] <= value; count[sel] <= value. Applied at the same edge.
- If sel == ptr in the same cycle, put wins: no decrement and no tick for that channel this cycle. ptr still advances.
- Put to a channel other than ptr does not disturb servicing of ptr.

Resulting tick rate:
- Channel with period P > 0 ticks once every P*N cycles after the first tick.
- First tick after put occurs on that channel's P-th service.

act behaviour:
- act[k] is 1 for exactly the cycle after the service cycle that ticked k.
- All other bits are 0, so act is zero or one-hot.

Arithmetic: W-bit unsigned. Decrement is applied only when count > 1, so it never wraps.

## Timing
- Service latency: the tick is decided in the service cycle and act rises at the next edge; it is 1 cycle wide.
- cur is combinational from ptr, not delayed; act[k] corresponds to cur == k of the previous cycle.
- Put takes effect at the edge where it is sampled. Reading state one cycle later shows period = count = value.
- A put at cycle t to channel k while ptr at t is j: k's next service occurs at t + ((k - j) mod N), or t + N if k == j.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and a pending act is dropped. Operation resumes with ptr = 0 on the first edge after deassertion.
- Throughput: one channel per cycle, fixed; no stalls.

## Configuration
- Macro TICK_SCHED_MASK_EN.
- Defined:
  - Adds input port mask, N bits, after put.
  - When ptr == k and mask[k] == 0, channel k is frozen: count held, no tick. period and count remain writable by put.
  - Clearing the mask resumes the countdown from the held count.
- Undefined:
  - No mask port; all channels are always serviced.
  - Behaviour is identical to the defined case with mask all ones.

## Test plan
- Reset with START = 0, N = 4, W = 8, no puts for 64 cycles -> act stays 0; cur cycles 0,1,2,3,0,...
- put sel = 2, value = 3 at cycle 0 (ptr = 0) -> act[2] high at cycles 11, 23, 35 (ticks every 12 cycles); act is never more than one-hot.
- put value = 1 to all four channels on consecutive cycles -> each act bit pulses every 4 cycles, so exactly one act bit is high every cycle in steady state.
- put to channel k coinciding with ptr == k while count[k] == 1 -> no act[k] that cycle; the next act[k] arrives value*N cycles later.
- put value = 0 to an active channel -> no further act for that channel; rewriting value = 2 restores ticks every 8 cycles.
- Assert reset mid-run while count[1] == 1 and ptr == 1 -> act stays 0, ptr = 0, all periods = START. With TICK_SCHED_MASK_EN: set mask[1] = 0 for 20 cycles -> no act[1], count[1] held; afterwards ticks resume from the held count.

Source files
------------

// File: rtl/tick_sched.sv
// Round-robin periodic tick scheduler: N channels share one decrement/compare path.
// Optional per-channel freeze mask enabled by defining TICK_SCHED_MASK_EN.
module tick_sched #(
  parameter int unsigned W     = 8,
  parameter int unsigned S     = 2,
  parameter int unsigned START = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [S-1:0]        sel,
  input  logic [W-1:0]        value,
  input  logic                put,
`ifdef TICK_SCHED_MASK_EN
  input  logic [(1<<S)-1:0]   mask,
`endif
  output logic [(1<<S)-1:0]   act,
  output logic [S-1:0]        cur
);

  localparam int unsigned N       = 1 << S;
  localparam logic [W-1:0] START_V = W'(START);

  logic [S-1:0] ptr_q, ptr_d;
  logic [W-1:0] period_q [N];
  logic [W-1:0] period_d [N];
  logic [W-1:0] count_q  [N];
  logic [W-1:0] count_d  [N];
  logic [N-1:0] act_q, act_d;
  logic         svc_en;
  logic [W-1:0] cur_period, cur_count;

`ifdef TICK_SCHED_MASK_EN
  assign svc_en = mask[ptr_q];
`else
  assign svc_en = 1'b1;
`endif

  always_comb begin
    period_d   = period_q;
    count_d    = count_q;
    act_d      = '0;
    ptr_d      = ptr_q + S'(1);
    cur_period = period_q[ptr_q];
    cur_count  = count_q[ptr_q];
    // A put to the serviced channel overrides its service; count==0 is treated as disabled.
    if (svc_en && !(put && sel == ptr_q) && cur_period != '0) begin
      if (cur_count == W'(1)) begin
        act_d[ptr_q]   = 1'b1;
        count_d[ptr_q] = cur_period;
      end else if (cur_count > W'(1)) begin
        count_d[ptr_q] = cur_count - W'(1);
      end
    end
    if (put) begin
      period_d[sel] = value;
      count_d[sel]  = value;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q    <= '0;
      period_q <= '{default: START_V};
      count_q  <= '{default: START_V};
      act_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      period_q <= period_d;
      count_q  <= count_d;
      act_q    <= act_d;
    end
  end

  assign act = act_q;
  assign cur = ptr_q;

endmodule

// File: tb/tb_tick_sched.sv
// Bench for tick_sched: vector table, hand sequences and random puts checked against
// a next-tick-time model of each channel.
module tb_tick_sched;
  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] sel;
  logic [7:0] value;
  logic       put;
  logic [3:0] act;
  logic [1:0] cur;
`ifdef TICK_SCHED_MASK_EN
  logic [3:0] mask;
`endif

  tick_sched #(.W(8), .S(2), .START(0)) dut (
    .clock (clock),
    .reset (reset),
    .sel   (sel),
    .value (value),
    .put   (put),
`ifdef TICK_SCHED_MASK_EN
    .mask  (mask),
`endif
    .act   (act),
    .cur   (cur)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc;
  int per [N];
  int nxt [N];

  typedef struct {
    bit         p;
    logic [1:0] s;
    logic [7:0] v;
    logic [3:0] a;
  } vec_t;
  vec_t tbl [12];

  // Model: each enabled channel has a period and the cycle its next act pulse appears.
  function automatic logic [3:0] model_act();
    logic [3:0] r = '0;
    for (int k = 0; k < N; k++)
      if (per[k] != 0 && nxt[k] == cyc) r[k] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      per[k] = 0;
      nxt[k] = -1;
    end
    cyc = 0;
  endtask

  task automatic model_put(input int k, input int v);
    int j, d, s;
    per[k] = v;
    if (v == 0) begin
      nxt[k] = -1;
    end else begin
      j = cyc % N;
      d = (k - j + N) % N;
      s = cyc + ((d == 0) ? N : d);
      nxt[k] = s + (v - 1) * N + 1;
    end
  endtask

  task automatic model_advance();
    for (int k = 0; k < N; k++)
      if (per[k] != 0 && nxt[k] == cyc) nxt[k] = nxt[k] + per[k] * N;
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  // Called at the negedge inside cycle cyc: check outputs, then drive this cycle's inputs.
  task automatic step(input bit p, input int s, input int v, input logic [3:0] exp_act);
    check("cur", 4'(cur), 4'(cyc % N));
    check("act", act, exp_act);
    model_advance();
    put   = p;
    sel   = 2'(s);
    value = 8'(v);
    if (p) model_put(s, v);
    @(negedge clock);
    cyc++;
  endtask

  task automatic mstep(input bit p, input int s, input int v);
    step(p, s, v, model_act());
  endtask

  task automatic do_reset();
    reset = 1'b1;
    put   = 1'b0;
    sel   = '0;
    value = '0;
`ifdef TICK_SCHED_MASK_EN
    mask  = '1;
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    do_reset();

    // Idle after reset: no ticks, pointer cycles.
    for (int c = 0; c < 64; c++) step(1'b0, 0, 0, 4'b0000);

    // Period 3 on channel 2 written while ptr == 0: pulses at 11, 23, 35.
    do_reset();
    for (int c = 0; c < 37; c++)
      step(c == 0, 2, 3, (c == 11 || c == 23 || c == 35) ? 4'b0100 : 4'b0000);

    // Period 1 on all channels, consecutive puts: one-hot every cycle from cycle 5.
    tbl[0]  = '{1'b1, 2'd0, 8'd1, 4'b0000};
    tbl[1]  = '{1'b1, 2'd1, 8'd1, 4'b0000};
    tbl[2]  = '{1'b1, 2'd2, 8'd1, 4'b0000};
    tbl[3]  = '{1'b1, 2'd3, 8'd1, 4'b0000};
    tbl[4]  = '{1'b0, 2'd0, 8'd0, 4'b0000};
    tbl[5]  = '{1'b0, 2'd0, 8'd0, 4'b0001};
    tbl[6]  = '{1'b0, 2'd0, 8'd0, 4'b0010};
    tbl[7]  = '{1'b0, 2'd0, 8'd0, 4'b0100};
    tbl[8]  = '{1'b0, 2'd0, 8'd0, 4'b1000};
    tbl[9]  = '{1'b0, 2'd0, 8'd0, 4'b0001};
    tbl[10] = '{1'b0, 2'd0, 8'd0, 4'b0010};
    tbl[11] = '{1'b0, 2'd0, 8'd0, 4'b0100};
    do_reset();
    for (int i = 0; i < 12; i++) step(tbl[i].p, int'(tbl[i].s), int'(tbl[i].v), tbl[i].a);

    // Put colliding with service of a channel at count 1: tick suppressed, next at +3*N.
    do_reset();
    for (int c = 0; c < 20; c++)
      step(c == 0 || c == 5, 1, (c == 0) ? 2 : 3, (c == 18) ? 4'b0010 : 4'b0000);

    // Disable with period 0, then re-enable with period 2.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      if (c == 0)       mstep(1'b1, 3, 1);
      else if (c == 10) mstep(1'b1, 3, 0);
      else if (c == 20) mstep(1'b1, 3, 2);
      else              mstep(1'b0, 0, 0);
    end

    // Asynchronous reset with an act pulse in flight.
    do_reset();
    for (int c = 0; c < 6; c++) mstep(c == 0, 1, 1);
    check("act_pre_reset", act, 4'b0010);
    reset = 1'b1;
    #1;
    check("act_async_reset", act, 4'b0000);
    check("cur_async_reset", 4'(cur), 4'd0);
    @(posedge clock);
    #1;
    check("act_reset_held", act, 4'b0000);
    check("cur_reset_held", 4'(cur), 4'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int c = 0; c < 20; c++) mstep(1'b0, 0, 0);

`ifdef TICK_SCHED_MASK_EN
    // Channel 1 frozen for 20 cycles with count 2, then resumes: pulses at 26 and 34.
    do_reset();
    for (int c = 0; c < 36; c++) begin
      mask = (c < 20) ? 4'b1101 : 4'b1111;
      step(c == 0, 1, 2, (c == 26 || c == 34) ? 4'b0010 : 4'b0000);
    end
    mask = '1;
`endif

    // Random puts against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(3) == 0) mstep(1'b1, int'($urandom_range(3)), int'($urandom_range(5)));
      else                        mstep(1'b0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
